// File: rtl/serial_subtractor_n.sv
// serial_subtractor_n: multi-cycle unsigned subtractor, D = A - B - bin.
// It handles CHUNK bits per clock, starting with the LSB chunk. A borrow
// register carries between chunks, so the datapath is one CHUNK-wide
// subtract slice plus the operand shift registers.
//
// Parameters:
//   N      operand/result width; must be a multiple of CHUNK
//   CHUNK  bits processed per BUSY cycle; must be >= 1 and divide N
//
// Ports:
//   clk, rst    clock (rising edge) and asynchronous active-high reset
//   in_valid    operands a, b, bin are valid
//   in_ready    high only in IDLE; operands are accepted on in_valid & in_ready
//   a, b, bin   minuend, subtrahend, borrow-in
//   out_valid   high only in DONE; d and bout (and ovf) are valid
//   out_ready   consumer accepts the result; DONE -> IDLE
//   d, bout     difference (mod 2^N) and borrow-out; both hold until the next result
//   ovf         signed overflow flag, present only when SUB_OVERFLOW_EN is defined
//
// Optional feature macro: SUB_OVERFLOW_EN (adds the ovf output).
module serial_subtractor_n #(
  parameter int unsigned N     = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic         ovf
`endif
);

  localparam int unsigned NCHUNK = N / CHUNK;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned SW     = CHUNK + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [N-1:0]   a_sr;
  logic [N-1:0]   b_sr;
  logic [N-1:0]   res_sr;
  logic [N-1:0]   res_next;
  logic           borrow_q;
  logic           borrow_next;
  logic [CW-1:0]  cnt_q;
  logic [SW-1:0]  slice;
  logic           last_chunk;
  logic           accept;
`ifdef SUB_OVERFLOW_EN
  logic           a_msb_q;
  logic           b_msb_q;
`endif

  // The subtract slice. The extra top bit of the (CHUNK+1)-bit difference is the borrow out.
  always_comb begin
    slice       = {1'b0, a_sr[CHUNK-1:0]} - {1'b0, b_sr[CHUNK-1:0]} - SW'(borrow_q);
    borrow_next = slice[CHUNK];
    // The new chunk enters from the MSB side, so after NCHUNK shifts the LSB chunk sits at bit 0.
    res_next    = (res_sr >> CHUNK) | (N'(slice[CHUNK-1:0]) << (N - CHUNK));
    last_chunk  = (cnt_q == CW'(NCHUNK - 1));
    accept      = (state_q == IDLE) && in_valid;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = BUSY;
      BUSY:    if (last_chunk) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state, so they always match state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
    end
  end

  // Operand shift registers, borrow chain and chunk counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else if (accept) begin
      a_sr     <= a;
      b_sr     <= b;
      res_sr   <= '0;
      borrow_q <= bin;
      cnt_q    <= '0;
    end else if (state_q == BUSY) begin
      a_sr     <= a_sr >> CHUNK;
      b_sr     <= b_sr >> CHUNK;
      res_sr   <= res_next;
      borrow_q <= borrow_next;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

  // Result registers. They load only when the last chunk completes and otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d    <= '0;
      bout <= 1'b0;
    end else if ((state_q == BUSY) && last_chunk) begin
      d    <= res_next;
      bout <= borrow_next;
    end
  end

`ifdef SUB_OVERFLOW_EN
  // Operand sign bits are captured at accept, because the shift registers discard them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (accept) begin
        a_msb_q <= a[N-1];
        b_msb_q <= b[N-1];
      end
      if ((state_q == BUSY) && last_chunk) begin
        ovf <= (a_msb_q != b_msb_q) && (res_next[N-1] != a_msb_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor_n.sv
module tb_serial_subtractor_n;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bout;
    logic       ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       bin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] d;
  logic       bout;
`ifdef SUB_OVERFLOW_EN
  logic       ovf;
`endif

  int vectors = 0;
  int miscompares = 0;

  serial_subtractor_n #(.N(8), .CHUNK(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Run one operation: accept, measure latency, check the result, then drain it.
  task automatic run_op(input vec_t v);
    int t;
    int cyc;
    logic [7:0] held;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("in_ready_before_op", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = v.a;
    b = v.b;
    bin = v.bin;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = ~v.a;
    b = ~v.b;
    bin = ~v.bin;
    chk("in_ready_after_accept", 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'd4);
    chk("d", 32'(d), 32'(v.d));
    chk("bout", 32'(bout), 32'(v.bout));
`ifdef SUB_OVERFLOW_EN
    chk("ovf", 32'(ovf), 32'(v.ovf));
`endif
    held = d;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("out_valid_after_drain", 32'(out_valid), 32'd0);
    chk("in_ready_after_drain", 32'(in_ready), 32'd1);
    chk("d_held_after_drain", 32'(d), 32'(held));
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  vec_t tbl[10];

  initial begin
    int cyc;
    //          a      b      bin   d      bout  ovf
    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[4] = '{8'h3C, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    tbl[6] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    tbl[7] = '{8'h12, 8'h34, 1'b0, 8'hDE, 1'b1, 1'b0};
    tbl[8] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1};
    tbl[9] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};

    // Reset state
    #3;
    chk("rst_d", 32'(d), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    for (int i = 0; i < 10; i++) run_op(tbl[i]);

    // Reset mid-operation discards the partial result and clears d.
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'hAA;
    b = 8'h55;
    bin = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_d", 32'(d), 32'd0);
    chk("midrst_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    run_op(tbl[8]);

    // Backpressure: DONE holds while out_ready is 0, and in_valid is ignored.
    @(negedge clk);
    in_valid = 1'b1;
    a = 8'h05;
    b = 8'h03;
    bin = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("bp_latency", 32'(cyc), 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      a = 8'hF0;
      b = 8'h0F;
      @(posedge clk);
      #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_d", 32'(d), 32'h02);
      chk("bp_bout", 32'(bout), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    // Nothing is accepted on the DONE->IDLE edge, even with in_valid high.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 8'h10;
    b = 8'h01;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("bp_no_accept", 32'(in_ready), 32'd1);
    chk("bp_d_held", 32'(d), 32'h02);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
